// File: rtl/lstm_cell_update_pkg.sv
// Shared fixed-point constants and FSM encoding for the LSTM cell-state update block.
package lstm_cell_update_pkg;

    localparam int WIDTH    = 32;
    localparam int FRAC     = 24;
    localparam int NUM_LSTM = 8;
    localparam int ADDR_W   = 9;

    localparam logic signed [WIDTH-1:0] ONE = 32'sh0100_0000;
    localparam logic signed [WIDTH-1:0] MAX = 32'sh7FFF_FFFF;
    localparam logic signed [WIDTH-1:0] MIN = 32'sh8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FC,
        S_IG,
        S_TH,
        S_OH,
        S_OUT
    } state_e;

endpackage

// File: rtl/lstm_cell_update_if.sv
// Gate-input / result handshake bundle between the gate neurons, the cell update and its consumer.
interface lstm_cell_update_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 9
);
    logic                     i_clr;
    logic                     i_valid;
    logic                     o_rdy;
    logic [ADDR_W-1:0]        i_addr;
    logic signed [WIDTH-1:0]  i_f;
    logic signed [WIDTH-1:0]  i_i;
    logic signed [WIDTH-1:0]  i_g;
    logic signed [WIDTH-1:0]  i_o;
    logic                     o_valid;
    logic                     i_rdy;
    logic [ADDR_W-1:0]        o_addr;
    logic signed [WIDTH-1:0]  o_c_old;
    logic signed [WIDTH-1:0]  o_c;
    logic signed [WIDTH-1:0]  o_h;

    modport slave (
        input  i_clr, i_valid, i_addr, i_f, i_i, i_g, i_o, i_rdy,
        output o_rdy, o_valid, o_addr, o_c_old, o_c, o_h
    );

    modport master (
        output i_clr, i_valid, i_addr, i_f, i_i, i_g, i_o, i_rdy,
        input  o_rdy, o_valid, o_addr, o_c_old, o_c, o_h
    );
endinterface

// File: rtl/lstm_cell_update_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC, saturate to WIDTH.
module fxp_mul_sat #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);
    localparam logic signed [2*WIDTH-1:0] P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;

    always_comb begin
        prod    = a * b;
        shifted = prod >>> FRAC;
        if (shifted > P_MAX) begin
            y = P_MAX[WIDTH-1:0];
        end else if (shifted < P_MIN) begin
            y = P_MIN[WIDTH-1:0];
        end else begin
            y = shifted[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/lstm_cell_update_tanh.sv
// Piecewise-linear tanh: |x|<0.5 -> |x|, |x|<1.5 -> 0.25+|x|/2, else 1.0; sign restored.
module tanh_pwl
    import lstm_cell_update_pkg::*;
(
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);
    localparam logic [WIDTH:0] ONE_E     = (WIDTH+1)'(ONE);
    localparam logic [WIDTH:0] HALF_E    = ONE_E >> 1;
    localparam logic [WIDTH:0] KNEE_E    = ONE_E + HALF_E;
    localparam logic [WIDTH-1:0] QUARTER = ONE >>> 2;

    logic signed [WIDTH:0] x_ext;
    logic [WIDTH:0]        mag;
    logic [WIDTH-1:0]      y_mag;

    always_comb begin
        x_ext = {x[WIDTH-1], x};
        mag   = x_ext[WIDTH] ? -x_ext : x_ext;
        if (mag < HALF_E) begin
            y_mag = WIDTH'(mag);
        end else if (mag < KNEE_E) begin
            y_mag = QUARTER + WIDTH'(mag >> 1);
        end else begin
            y_mag = ONE;
        end
        y = x[WIDTH-1] ? -y_mag : y_mag;
    end
endmodule

// File: rtl/lstm_cell_update.sv
// LSTM cell update: c_new = f*c_old + i*g, h = o*tanh(c_new), one shared multiplier sequenced by an FSM.
module lstm_cell_update #(
    parameter int WIDTH    = lstm_cell_update_pkg::WIDTH,
    parameter int FRAC     = lstm_cell_update_pkg::FRAC,
    parameter int NUM_LSTM = lstm_cell_update_pkg::NUM_LSTM
) (
    input logic              clk,
    input logic              rst,
    lstm_cell_update_if.slave bus
);
    import lstm_cell_update_pkg::*;

    localparam int IDX_W = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1;
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(NUM_LSTM);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d, out_addr_q, out_addr_d;
    logic signed [WIDTH-1:0] f_q, f_d, i_q, i_d, g_q, g_d, o_q, o_d;
    logic signed [WIDTH-1:0] c_old_q, c_old_d, acc_q, acc_d, c_new_q, c_new_d, t_q, t_d;
    logic signed [WIDTH-1:0] out_c_old_q, out_c_old_d, out_c_q, out_c_d, out_h_q, out_h_d;
    logic signed [WIDTH-1:0] c_mem_q [NUM_LSTM];
    logic signed [WIDTH-1:0] c_mem_d [NUM_LSTM];
    logic signed [WIDTH-1:0] mul_a, mul_b, mul_y, tanh_y, sum_sat;
    logic signed [WIDTH:0]   sum_ext;
    logic                    accept;

    fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (.a(mul_a), .b(mul_b), .y(mul_y));
    tanh_pwl u_tanh (.x(c_new_q), .y(tanh_y));

    assign accept = (state_q == S_IDLE) && !bus.i_clr && bus.i_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_FC;
            S_FC:    state_d = S_IG;
            S_IG:    state_d = S_TH;
            S_TH:    state_d = S_OH;
            S_OH:    state_d = S_OUT;
            S_OUT:   if (bus.i_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_rdy   = (state_q == S_IDLE) && !bus.i_clr;
        bus.o_valid = (state_q == S_OUT);
        bus.o_addr  = out_addr_q;
        bus.o_c_old = out_c_old_q;
        bus.o_c     = out_c_q;
        bus.o_h     = out_h_q;
    end

    // Shared multiplier operands follow the step: f*c_old, then i*g, then o*tanh(c_new).
    always_comb begin
        mul_a = f_q;
        mul_b = c_old_q;
        case (state_q)
            S_IG:    begin mul_a = i_q; mul_b = g_q; end
            S_OH:    begin mul_a = o_q; mul_b = t_q; end
            default: ;
        endcase
        sum_ext = {acc_q[WIDTH-1], acc_q} + {mul_y[WIDTH-1], mul_y};
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
            sum_sat = sum_ext[WIDTH] ? MIN : MAX;
        end else begin
            sum_sat = sum_ext[WIDTH-1:0];
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        addr_d      = addr_q;
        f_d         = f_q;
        i_d         = i_q;
        g_d         = g_q;
        o_d         = o_q;
        c_old_d     = c_old_q;
        acc_d       = acc_q;
        c_new_d     = c_new_q;
        t_d         = t_q;
        c_mem_d     = c_mem_q;
        out_addr_d  = out_addr_q;
        out_c_old_d = out_c_old_q;
        out_c_d     = out_c_q;
        out_h_d     = out_h_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_clr) begin
                    for (int k = 0; k < NUM_LSTM; k++) c_mem_d[k] = '0;
                end else if (accept) begin
                    addr_d  = bus.i_addr;
                    f_d     = bus.i_f;
                    i_d     = bus.i_i;
                    g_d     = bus.i_g;
                    o_d     = bus.i_o;
                    c_old_d = (bus.i_addr < DEPTH) ? c_mem_q[bus.i_addr[IDX_W-1:0]] : '0;
                end
            end
            S_FC: acc_d = mul_y;
            S_IG: begin
                c_new_d = sum_sat;
                if (addr_q < DEPTH) c_mem_d[addr_q[IDX_W-1:0]] = sum_sat;
            end
            S_TH: t_d = tanh_y;
            S_OH: begin
                out_addr_d  = addr_q;
                out_c_old_d = c_old_q;
                out_c_d     = c_new_q;
                out_h_d     = mul_y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q      <= '0;
            f_q         <= '0;
            i_q         <= '0;
            g_q         <= '0;
            o_q         <= '0;
            c_old_q     <= '0;
            acc_q       <= '0;
            c_new_q     <= '0;
            t_q         <= '0;
            out_addr_q  <= '0;
            out_c_old_q <= '0;
            out_c_q     <= '0;
            out_h_q     <= '0;
            // NOTE: the cell-state store is a small flop array, so it is cleared by reset like any register.
            for (int k = 0; k < NUM_LSTM; k++) c_mem_q[k] <= '0;
        end else begin
            addr_q      <= addr_d;
            f_q         <= f_d;
            i_q         <= i_d;
            g_q         <= g_d;
            o_q         <= o_d;
            c_old_q     <= c_old_d;
            acc_q       <= acc_d;
            c_new_q     <= c_new_d;
            t_q         <= t_d;
            out_addr_q  <= out_addr_d;
            out_c_old_q <= out_c_old_d;
            out_c_q     <= out_c_d;
            out_h_q     <= out_h_d;
            c_mem_q     <= c_mem_d;
        end
    end
endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update: arithmetic model, per-cycle result compare, literal anchors.
module tb_lstm_cell_update;
    import lstm_cell_update_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lstm_cell_update_if #(.WIDTH(32), .ADDR_W(9)) bus ();

    lstm_cell_update dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] c_old;
        logic [31:0] c;
        logic [31:0] h;
    } exp_t;

    exp_t               exp_q[$];
    logic signed [31:0] mem_m [8];
    int                 n_checks = 0;
    int                 n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    function automatic logic signed [31:0] sat32(input longint v);
        if (v > 64'sh7FFF_FFFF) return 32'sh7FFF_FFFF;
        if (v < -64'sh8000_0000) return 32'sh8000_0000;
        return 32'(v);
    endfunction

    function automatic logic signed [31:0] mul_ref(input logic signed [31:0] a, input logic signed [31:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat32(p >>> 24);
    endfunction

    function automatic logic signed [31:0] tanh_ref(input logic signed [31:0] x);
        real    a, y;
        longint m;
        a = $itor(x) / 16777216.0;
        if (a < 0.0) a = -a;
        if (a < 0.5)      y = a;
        else if (a < 1.5) y = 0.25 + a / 2.0;
        else              y = 1.0;
        m = longint'($floor(y * 16777216.0));
        return (x < 0) ? 32'(-m) : 32'(m);
    endfunction

    always @(negedge clk) begin
        if (rst && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_valid: o_valid=1 with o_addr=%0d and no transaction pending", bus.o_addr);
            end else begin
                check("out_addr", 32'(bus.o_addr), 32'(exp_q[0].addr));
                check("out_c_old", bus.o_c_old, exp_q[0].c_old);
                check("out_c", bus.o_c, exp_q[0].c);
                check("out_h", bus.o_h, exp_q[0].h);
                if (bus.i_rdy) void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the result handshake.
    task automatic send(input logic [8:0] a, input logic [31:0] f, input logic [31:0] i,
                        input logic [31:0] g, input logic [31:0] o, input int hold);
        int   k;
        exp_t e;
        logic signed [31:0] c_old, cn;
        k = 0;
        while (!bus.o_rdy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("rdy_before_send", 32'(bus.o_rdy), 32'd1);
        bus.i_addr = a; bus.i_f = f; bus.i_i = i; bus.i_g = g; bus.i_o = o;
        bus.i_valid = 1'b1;
        c_old = (a < 9'd8) ? mem_m[a[2:0]] : 32'sd0;
        cn    = sat32(longint'(mul_ref(f, c_old)) + longint'(mul_ref(i, g)));
        if (a < 9'd8) mem_m[a[2:0]] = cn;
        e.addr = a; e.c_old = c_old; e.c = cn; e.h = mul_ref(o, tanh_ref(cn));
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_rdy   = (hold == 0);
        for (k = 1; k < 9; k++) begin
            @(posedge clk); #1;
            if (bus.o_valid) break;
        end
        check("latency", 32'(k), 32'd4);
        if (hold > 0) begin
            repeat (hold) begin
                check("bp_rdy", 32'(bus.o_rdy), 32'd0);
                check("bp_valid", 32'(bus.o_valid), 32'd1);
                bus.i_addr  = 9'd3;
                bus.i_valid = 1'b1;
                @(posedge clk); #1;
            end
            bus.i_valid = 1'b0;
            bus.i_rdy   = 1'b1;
        end
        @(posedge clk); #1;
        check("valid_drop", 32'(bus.o_valid), 32'd0);
        check("rdy_back", 32'(bus.o_rdy), 32'd1);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) mem_m[k] = 32'sd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.i_clr = 1'b0; bus.i_valid = 1'b0; bus.i_rdy = 1'b1; bus.i_addr = '0;
        bus.i_f = '0; bus.i_i = '0; bus.i_g = '0; bus.i_o = '0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_addr", 32'(bus.o_addr), 32'd0);
        check("rst_c_old", bus.o_c_old, 32'd0);
        check("rst_c", bus.o_c, 32'd0);
        check("rst_h", bus.o_h, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_rst", 32'(bus.o_rdy), 32'd1);

        bus.i_clr = 1'b1;
        #1 check("clr_rdy", 32'(bus.o_rdy), 32'd0);
        @(posedge clk); #1;
        bus.i_clr = 1'b0;
        model_clear();

        // First transaction on unit 0 and its repeat
        send(9'd0, 32'h0080_0000, 32'h0100_0000, 32'h0080_0000, 32'h0100_0000, 0);
        check("t1_c_old", bus.o_c_old, 32'h0000_0000);
        check("t1_c", bus.o_c, 32'h0080_0000);
        check("t1_h", bus.o_h, 32'h0080_0000);
        send(9'd0, 32'h0080_0000, 32'h0100_0000, 32'h0080_0000, 32'h0100_0000, 0);
        check("t2_c_old", bus.o_c_old, 32'h0080_0000);
        check("t2_c", bus.o_c, 32'h00C0_0000);
        check("t2_h", bus.o_h, 32'h00A0_0000);
        send(9'd1, ONE, 32'h0, 32'h0, ONE, 0);
        check("u1_c", bus.o_c, 32'h0);

        // Saturation both ways
        send(9'd2, 32'h0, MAX, MAX, ONE, 0);
        check("sat_hi_c", bus.o_c, 32'h7FFF_FFFF);
        check("sat_hi_h", bus.o_h, 32'h0100_0000);
        send(9'd2, 32'h0, MAX, MIN, ONE, 0);
        check("sat_lo_c", bus.o_c, 32'h8000_0000);
        check("sat_lo_h", bus.o_h, 32'hFF00_0000);

        // Ten cycles of backpressure in OUT
        send(9'd5, ONE, ONE, 32'h0040_0000, 32'h0080_0000, 10);
        check("bp_h", bus.o_h, 32'h0020_0000);

        // Clear together with valid: no acceptance, all cells zeroed
        bus.i_clr = 1'b1; bus.i_valid = 1'b1; bus.i_addr = 9'd0;
        #1 check("clr_valid_rdy", 32'(bus.o_rdy), 32'd0);
        @(posedge clk); #1;
        bus.i_clr = 1'b0; bus.i_valid = 1'b0;
        model_clear();
        repeat (4) @(posedge clk);
        #1 check("clr_no_accept", 32'(bus.o_valid), 32'd0);
        send(9'd7, ONE, 32'h0, 32'h0, ONE, 0);
        check("u7_c", bus.o_c, 32'h0);
        send(9'd0, ONE, 32'h0, 32'h0, ONE, 0);
        check("u0_cleared", bus.o_c_old, 32'h0);

        // Out-of-range unit: reads zero, never writes
        send(9'd9, ONE, ONE, 32'h0080_0000, ONE, 0);
        check("oor_addr", 32'(bus.o_addr), 32'd9);
        check("oor_c", bus.o_c, 32'h0080_0000);
        send(9'd9, ONE, ONE, 32'h0080_0000, ONE, 0);
        check("oor_c_old", bus.o_c_old, 32'h0);
        send(9'd1, ONE, 32'h0, 32'h0, ONE, 0);
        check("oor_no_alias", bus.o_c_old, 32'h0);

        // Reset while in TH
        send(9'd3, 32'h0, ONE, ONE, ONE, 0);
        check("u3_c", bus.o_c, 32'h0100_0000);
        bus.i_addr = 9'd4; bus.i_f = '0; bus.i_i = ONE; bus.i_g = ONE; bus.i_o = ONE;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        check("abort_valid", 32'(bus.o_valid), 32'd0);
        check("abort_addr", 32'(bus.o_addr), 32'd0);
        check("abort_c_old", bus.o_c_old, 32'h0);
        check("abort_c", bus.o_c, 32'h0);
        check("abort_h", bus.o_h, 32'h0);
        check("abort_rdy", 32'(bus.o_rdy), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        send(9'd3, ONE, 32'h0, 32'h0, ONE, 0);
        check("u3_after_rst", bus.o_c_old, 32'h0);
        send(9'd4, ONE, 32'h0, 32'h0, ONE, 0);
        check("u4_after_rst", bus.o_c_old, 32'h0);
        send(9'd0, 32'h0080_0000, 32'h0100_0000, 32'h0080_0000, 32'h0100_0000, 0);
        check("t3_c_old", bus.o_c_old, 32'h0000_0000);
        check("t3_c", bus.o_c, 32'h0080_0000);
        check("t3_h", bus.o_h, 32'h0080_0000);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/lstm_cell_update.md
Name: lstm_cell_update

Overview:
- Sits directly downstream of the LSTM gate neurons: the sigmoid f/i/o gates and the tanh candidate g.
- Consumes one unit's four gate activations per transaction and holds the per-unit cell state c.
- Computes c_new = f*c_old + i*g and h = o*tanh(c_new), then returns c_old, c_new and h for the next timestep and for backpropagation.
- A single shared multiplier is time-multiplexed by a small FSM.

Parameters:
- WIDTH, 32, signed fixed-point word width.
- FRAC, 24, fraction bits (Q8.24; 1.0 = 0x01000000).
- NUM_LSTM, 8, number of LSTM units, i.e. the cell-state memory depth.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- i_clr  in  1  zero all cell states (sequence start).
- i_valid  in  1  gate inputs valid.
- o_rdy  out  1  block can accept inputs.
- i_addr  in  9  LSTM unit index.
- i_f, i_i, i_g, i_o  in  WIDTH each  forget / input / candidate / output activations.
- o_valid  out  1  results valid.
- i_rdy  in  1  downstream accepts results.
- o_addr  out  9  unit index of the results.
- o_c_old  out  WIDTH  previous cell state.
- o_c  out  WIDTH  new cell state.
- o_h  out  WIDTH  hidden output.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE and all c_mem entries are zeroed.
  - o_valid=0, o_addr=0, o_c_old=0, o_c=0, o_h=0. o_rdy=1 on the first cycle after rst returns high.
  - Reset mid-operation aborts the transaction: no memory write, no o_valid.
- FSM states: IDLE, FC, IG, TH, OH, OUT.
- IDLE:
  - o_rdy = 1 & !i_clr.
  - i_clr=1 zeroes all c_mem at that edge. clr has priority over i_valid; that input is not accepted.
  - i_valid & o_rdy: latch addr, f, i, g, o; latch c_old = c_mem[addr] (0 if addr >= NUM_LSTM); go to FC.
- FC: acc <= mul(f, c_old); go to IG.
- IG: c_new <= sat(acc + mul(i, g)); c_mem[addr] <= c_new (write skipped if addr >= NUM_LSTM); go to TH.
- TH: t <= tanh(c_new) through the existing tanh module; go to OH.
- OH: h <= mul(o, t); go to OUT.
- OUT:
  - o_valid=1 and o_addr/o_c_old/o_c/o_h are driven.
  - On i_rdy=1, go to IDLE; o_valid drops the next cycle.
  - With i_rdy=0, hold all outputs stable.
  - i_clr is ignored outside IDLE.
- Output registers keep their last value after OUT. Only o_valid qualifies them.
- Latency:
  - o_valid rises on the 4th clock edge after the accepting edge.
  - Minimum initiation interval is 6 cycles: back-to-back, o_rdy is high in the cycle after the i_rdy handshake.
- Arithmetic (mul):
  - Full 2*WIDTH signed product, arithmetic right shift by FRAC (truncation toward -inf).
  - Saturate to [0x80000000, 0x7FFFFFFF].
  - Addition is signed and saturating to the same bounds.
- Same-address back-to-back transactions see the value written by the previous transaction. The write completes before returning to IDLE.

Decomposition:
- Shared include/package lstm_defs: WIDTH, FRAC, ONE constant, state encodings, MAX/MIN saturation constants.
- One sub-module, fxp_mul_sat (two WIDTH inputs, WIDTH saturated output, params WIDTH/FRAC), instanced once and muxed by state.
- tanh is reused unchanged.

Test Plan:
- Reset then clr; addr=0, f=0x00800000, i=0x01000000, g=0x00800000, o=0x01000000 -> after 4 edges o_valid=1, o_c_old=0, o_c=0x00800000, o_h = tanh(0x00800000) as produced by the tanh model.
- Repeat identical inputs on addr=0 -> o_c_old=0x00800000, o_c=0x00C00000; addr=1 stays 0 (check with f=1.0, i=0 on addr=1 -> o_c=0).
- Saturation: i=g=0x7FFFFFFF, f=0 -> o_c=0x7FFFFFFF. Then i=0x7FFFFFFF, g=0x80000000 -> o_c=0x80000000.
- Backpressure: i_rdy=0 for 10 cycles in OUT -> o_valid and all outputs stable, o_rdy=0, a new i_valid is not accepted. i_rdy=1 -> IDLE next cycle.
- i_clr and i_valid together in IDLE -> not accepted, all c_mem=0. addr=7 with f=1.0, i=0 -> o_c=0. addr=9 (out of range) -> o_c_old=0, no memory write.
- rst=0 asserted during TH -> no o_valid, written state zeroed, outputs 0. The following transaction behaves as in the first scenario.
